fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline. It owns the PC, issues instruction-memory requests on a req/ack handshake that tolerates variable latency, and applies EX-stage redirects and hazard stall/flush. It drives the IF/ID register, whose instruction output feeds the pipeline controller's ID-stage decode (Di_inst) and the datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) inserted into IF/ID

Ports:
clk  input  1  clock, all state updates on rising edge
reset_x  input  1  asynchronous reset, active-high (reset_x=1 resets)
Fo_imemReq  output  1  instruction fetch request
Fo_imemAddr  output  32  fetch address, bits[1:0] always 0
Fi_imemAck  input  1  response valid; data on Fi_imemRdata this cycle; may be same cycle as req
Fi_imemRdata  input  32  fetched instruction
Fi_stall  input  1  from hazard unit: hold PC and IF/ID
Di_flush  input  1  from hazard unit: clear IF/ID to bubble
Ei_PCSrc  input  2  00 sequential, 01 branch/jal target, 10 jalr target, 11 reserved (treated as 00)
Ei_PCTarget  input  32  PC+imm from EX
Ei_ALUResult  input  32  jalr target from EX
Do_inst  output  32  IF/ID instruction
Do_PC  output  32  IF/ID PC
Do_PCPlus4  output  32  IF/ID PC+4
Do_valid  output  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset (async, any state): PC=RESET_PC, state=IDLE, kill=0, buffer empty, Do_inst=NOP_INST, Do_PC=0, Do_PCPlus4=0, Do_valid=0, Fo_imemReq=0.
- States: IDLE, REQ (request outstanding), HOLD (response buffered under stall), DRAIN (killed request outstanding).
- IDLE -> REQ on the first clock after reset deasserts.
- REQ: Fo_imemReq=1, Fo_imemAddr=PC; req and addr stay stable until ack.
  - ack, no stall, no redirect: IF/ID <= {Rdata, PC, PC+4, valid=1}; PC<=PC+4; stay REQ (1 instr/cycle with 0-latency memory).
  - ack with stall: capture into 1-entry buffer, PC<=PC+4, -> HOLD.
  - no ack, no stall: IF/ID <= bubble.
- HOLD: Fo_imemReq=0. When stall drops: IF/ID <= buffer, valid=1, -> REQ.
- Stall without ack: IF/ID and PC hold.
- Redirect (Ei_PCSrc=01/10) has priority over stall and over sequential update:
  - PC <= Ei_PCTarget (01) or Ei_ALUResult & ~32'h3 (10). Bits [1:0] are always forced to 0.
  - Buffer is discarded.
  - Request outstanding without ack this cycle: -> DRAIN, Fo_imemReq=0. On ack, data is dropped -> REQ.
  - Ack in the same cycle: data is dropped -> REQ.
- Di_flush: IF/ID <= {NOP_INST, 0, 0, valid=0}. Flush beats stall and load. The hazard unit asserts it together with every redirect.
- Stall and flush together: flush wins on IF/ID; PC/buffer follow the stall rules.
- Ack in IDLE or HOLD: ignored; this is a memory protocol violation (assertion in the bench).
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

Decomposition:
- Shared package pipe_pkg: NOP_INST, PCSrc encodings (PCSRC_SEQ/BR/JALR), fetch state enum.
- IF/ID register built as an instance of the team's enable/clear flop dffREC (width 97, enable=~Fi_stall|Di_flush, clear=Di_flush).
- No other sub-modules.

Test Plan:
- Reset with RESET_PC=0, 0-latency memory returning addr-tagged words -> Do_PC sequence 0,4,8,… one per cycle; Do_valid=1 from the second cycle.
- Memory latency 3 cycles -> each instruction is preceded by 3 bubbles (Do_inst=32'h13, valid=0); Fo_imemAddr is stable while req=1.
- Ack at PC=8 while Fi_stall=1 for 2 cycles -> IF/ID holds prior instruction, Fo_imemReq=0; after release Do_PC=8, then 12 is requested.
- Latency 2, Ei_PCSrc=01, target 0x100 while fetch of 0x10 is outstanding -> 0x10 data never appears in IF/ID; next valid Do_PC=0x100.
- Ei_PCSrc=10, ALUResult=0x203 with Di_flush=1 -> Fo_imemAddr=0x200; IF/ID bubble that cycle.
- reset_x pulsed mid-REQ -> outputs return to reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline constants, PC-source encodings and fetch state type
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  localparam int IFID_W = 97;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_HOLD,
    F_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/dffREC.sv
// rtl/dffREC.sv - register with enable and synchronous clear, async reset
module dffREC #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Clear reloads the reset value and overrides the enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= RST_VAL;
    end else if (i_clr) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, variable-latency imem req/ack fetch, redirect/stall/flush, IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        reset_x,
  output logic        Fo_imemReq,
  output logic [31:0] Fo_imemAddr,
  input  logic        Fi_imemAck,
  input  logic [31:0] Fi_imemRdata,
  input  logic        Fi_stall,
  input  logic        Di_flush,
  input  logic [1:0]  Ei_PCSrc,
  input  logic [31:0] Ei_PCTarget,
  input  logic [31:0] Ei_ALUResult,
  output logic [31:0] Do_inst,
  output logic [31:0] Do_PC,
  output logic [31:0] Do_PCPlus4,
  output logic        Do_valid
);

  import pipe_pkg::*;

  localparam ifid_t IFID_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_req;
  logic [31:0]  r_buf_inst;
  logic [31:0]  r_buf_pc;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_plus4;
  logic         w_fetch_ack;
  logic         w_ifid_en;
  ifid_t        w_ifid_d;
  ifid_t        w_ifid_q;

  assign w_redirect  = (Ei_PCSrc == PCSRC_BR) || (Ei_PCSrc == PCSRC_JALR);
  assign w_target    = ((Ei_PCSrc == PCSRC_JALR) ? Ei_ALUResult : Ei_PCTarget) & ~32'h3;
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_fetch_ack = (r_state == F_REQ) && Fi_imemAck;

  // A redirect always drops whatever is arriving or buffered this cycle.
  always_comb begin
    w_ifid_d = IFID_BUBBLE;
    if (!w_redirect) begin
      if (w_fetch_ack) begin
        w_ifid_d = '{inst: Fi_imemRdata, pc: r_pc, pc_plus4: w_pc_plus4, valid: 1'b1};
      end else if (r_state == F_HOLD) begin
        w_ifid_d = '{inst: r_buf_inst, pc: r_buf_pc, pc_plus4: r_buf_pc + 32'd4, valid: 1'b1};
      end
    end
  end

  assign w_ifid_en = ~Fi_stall | Di_flush;

  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      r_state    <= F_IDLE;
      r_pc       <= RESET_PC & ~32'h3;
      r_req      <= 1'b0;
      r_buf_inst <= NOP_INST;
      r_buf_pc   <= 32'h0;
    end else begin
      case (r_state)
        F_IDLE: begin
          r_state <= F_REQ;
          r_req   <= 1'b1;
          if (w_redirect) r_pc <= w_target;
        end
        F_REQ: begin
          if (w_redirect) begin
            r_pc <= w_target;
            if (!Fi_imemAck) begin
              r_state <= F_DRAIN;
              r_req   <= 1'b0;
            end
          end else if (Fi_imemAck) begin
            r_pc <= w_pc_plus4;
            if (Fi_stall) begin
              r_buf_inst <= Fi_imemRdata;
              r_buf_pc   <= r_pc;
              r_state    <= F_HOLD;
              r_req      <= 1'b0;
            end
          end
        end
        F_HOLD: begin
          if (w_redirect) r_pc <= w_target;
          if (w_redirect || !Fi_stall) begin
            r_state <= F_REQ;
            r_req   <= 1'b1;
          end
        end
        F_DRAIN: begin
          // The killed response still has to arrive before a new request is issued.
          if (w_redirect) r_pc <= w_target;
          if (Fi_imemAck) begin
            r_state <= F_REQ;
            r_req   <= 1'b1;
          end
        end
        default: begin
          r_state <= F_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  dffREC #(
    .W       (IFID_W),
    .RST_VAL (IFID_BUBBLE)
  ) u_ifid (
    .i_clk (clk),
    .i_rst (reset_x),
    .i_en  (w_ifid_en),
    .i_clr (Di_flush),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  assign Fo_imemReq  = r_req;
  assign Fo_imemAddr = r_pc;
  assign Do_inst     = w_ifid_q.inst;
  assign Do_PC       = w_ifid_q.pc;
  assign Do_PCPlus4  = w_ifid_q.pc_plus4;
  assign Do_valid    = w_ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven bench for fetch_stage with a variable-latency imem model
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic        flush;
  logic [1:0]  src;
  logic [31:0] tgt;
  logic [31:0] alu;
  logic [31:0] d_inst;
  logic [31:0] d_pc;
  logic [31:0] d_pcp4;
  logic        d_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset_x      (rst),
    .Fo_imemReq   (req),
    .Fo_imemAddr  (addr),
    .Fi_imemAck   (ack),
    .Fi_imemRdata (rdata),
    .Fi_stall     (stall),
    .Di_flush     (flush),
    .Ei_PCSrc     (src),
    .Ei_PCTarget  (tgt),
    .Ei_ALUResult (alu),
    .Do_inst      (d_inst),
    .Do_PC        (d_pc),
    .Do_PCPlus4   (d_pcp4),
    .Do_valid     (d_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: latency 0 acks combinationally; latency N acks N cycles after the request is seen,
  // and completes even if the request is withdrawn meanwhile.
  int          mem_lat;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;

  always_comb begin
    ack   = m_busy ? (m_cnt == 0) : ((mem_lat == 0) && req);
    rdata = mem_word(m_busy ? m_addr : addr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_addr <= 32'h0;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end else if (req && (mem_lat > 0)) begin
      m_busy <= 1'b1;
      m_cnt  <= mem_lat - 1;
      m_addr <= addr;
    end
  end

  always @(negedge clk) begin
    if (!rst) assert (!(ack && !req && !m_busy)) else $error("FAIL mem_protocol ack with no request");
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] alu;
    int          lat;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic f, input logic [1:0] ps, input logic [31:0] t,
                              input logic [31:0] a, input int l, input logic rq, input logic [31:0] ad,
                              input logic [31:0] in, input logic [31:0] p, input logic v);
    vec_t r;
    r.stall = s; r.flush = f; r.src = ps; r.tgt = t; r.alu = a; r.lat = l;
    r.req = rq; r.addr = ad; r.inst = in; r.pc = p; r.valid = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ereq, input logic [31:0] eaddr,
                               input logic [31:0] einst, input logic [31:0] epc, input logic evalid);
    check({tag, "_req"},   {31'b0, req},     {31'b0, ereq});
    check({tag, "_addr"},  addr,             eaddr);
    check({tag, "_inst"},  d_inst,           einst);
    check({tag, "_pc"},    d_pc,             epc);
    check({tag, "_pcp4"},  d_pcp4,           evalid ? epc + 32'd4 : 32'h0);
    check({tag, "_valid"}, {31'b0, d_valid}, {31'b0, evalid});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int          bubbles;
    logic        got;
    logic        addr_ok;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; src = 2'b00; tgt = 32'h0; alu = 32'h0; mem_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    rst = 1'b0;

    // stall, flush, src, tgt, alu, lat | req, addr, inst, pc, valid
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h0,       NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h4,       mem_word(32'h0),      32'h0,       1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h8,       mem_word(32'h4),      32'h4,       1));
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 0,32'hC,       mem_word(32'h4),      32'h4,       1));
    vecs.push_back(mk(1,0,2'b00,32'h0,32'h0,0, 0,32'hC,       mem_word(32'h4),      32'h4,       1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'hC,       mem_word(32'h8),      32'h8,       1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h10,      mem_word(32'hC),      32'hC,       1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,2, 1,32'h10,      NOP,                  32'h0,       0));
    vecs.push_back(mk(0,1,2'b01,32'h100,32'h0,2, 0,32'h100,   NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,2, 1,32'h100,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,2, 1,32'h100,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,2, 1,32'h100,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,2, 1,32'h104,     mem_word(32'h100),    32'h100,     1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,3, 1,32'h104,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,3, 1,32'h104,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,3, 1,32'h104,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,3, 1,32'h108,     mem_word(32'h104),    32'h104,     1));
    vecs.push_back(mk(0,1,2'b10,32'h0,32'h203,0, 1,32'h200,   NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h204,     mem_word(32'h200),    32'h200,     1));
    vecs.push_back(mk(0,0,2'b11,32'h400,32'h0,0, 1,32'h208,   mem_word(32'h204),    32'h204,     1));
    vecs.push_back(mk(1,1,2'b00,32'h0,32'h0,0, 0,32'h20C,     NOP,                  32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h20C,     mem_word(32'h208),    32'h208,     1));
    vecs.push_back(mk(0,1,2'b01,32'hFFFF_FFFE,32'h0,0, 1,32'hFFFF_FFFC, NOP,        32'h0,       0));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h0,       mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(0,0,2'b00,32'h0,32'h0,0, 1,32'h4,       mem_word(32'h0),      32'h0,       1));

    foreach (vecs[i]) begin
      stall = vecs[i].stall; flush = vecs[i].flush; src = vecs[i].src;
      tgt = vecs[i].tgt; alu = vecs[i].alu; mem_lat = vecs[i].lat;
      @(posedge clk);
      #1;
      check_outputs($sformatf("row%0d", i), vecs[i].req, vecs[i].addr, vecs[i].inst, vecs[i].pc, vecs[i].valid);
    end

    // Reset pulse while a 3-cycle fetch is outstanding.
    stall = 1'b0; flush = 1'b0; src = 2'b00; tgt = 32'h0; alu = 32'h0; mem_lat = 3;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_outputs("midreset", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    bubbles = 0; got = 1'b0; addr_ok = 1'b1;
    for (int k = 0; k < 12 && !got; k++) begin
      @(posedge clk);
      #1;
      if (d_valid) got = 1'b1;
      else begin
        bubbles++;
        if (req && addr != 32'h0) addr_ok = 1'b0;
      end
    end
    check("restart_valid",       {31'b0, got},     32'h1);
    check("restart_pc",          d_pc,             32'h0);
    check("restart_inst",        d_inst,           mem_word(32'h0));
    check("restart_bubbles",     bubbles,          32'd4);
    check("restart_addr_stable", {31'b0, addr_ok}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
